// File: rtl/car_alarm_chime.sv
// Car warning chime: debounced alarm input driving a bounded beep sequence
// with driver mute and auto-silence after MAX_BEEPS beeps.
module car_alarm_chime #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int ON_CYC       = 8,
    parameter int OFF_CYC      = 8,
    parameter int MAX_BEEPS    = 5
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic       Alarm,
    input  logic       Mute,
    output logic       Buzzer,
    output logic       Active,
    output logic [2:0] BeepCnt
);

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF,
        HOLD
    } state_t;

    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYC - 1);
    localparam logic [7:0] ON_LD   = 8'(ON_CYC);
    localparam logic [7:0] OFF_LD  = 8'(OFF_CYC);
    localparam logic [2:0] MAX_CNT = 3'(MAX_BEEPS);

    state_t     state;
    state_t     state_nx;
    logic       alarm_db;
    logic [3:0] db_cnt;
    logic [7:0] timer;
    logic [7:0] timer_nx;
    logic [2:0] beep_nx;
    logic       expired;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            alarm_db <= 1'b0;
            db_cnt   <= 4'd0;
        end else if (Alarm == alarm_db) begin
            db_cnt <= 4'd0;
        end else if (db_cnt == DB_LAST) begin
            alarm_db <= Alarm;
            db_cnt   <= 4'd0;
        end else begin
            db_cnt <= db_cnt + 4'd1;
        end
    end

    assign Active  = alarm_db;
    assign expired = (timer <= 8'd1);

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        beep_nx  = BeepCnt;
        // Losing the debounced alarm outranks mute and timer expiry
        if (!alarm_db) begin
            state_nx = IDLE;
            timer_nx = 8'd0;
            beep_nx  = 3'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nx = ON;
                    timer_nx = ON_LD;
                    beep_nx  = 3'd0;
                end
                ON: begin
                    if (Mute) begin
                        state_nx = HOLD;
                    end else if (expired) begin
                        beep_nx = BeepCnt + 3'd1;
                        if (beep_nx == MAX_CNT) begin
                            state_nx = HOLD;
                        end else begin
                            state_nx = OFF;
                            timer_nx = OFF_LD;
                        end
                    end else begin
                        timer_nx = timer - 8'd1;
                    end
                end
                OFF: begin
                    if (Mute) begin
                        state_nx = HOLD;
                    end else if (expired) begin
                        state_nx = ON;
                        timer_nx = ON_LD;
                    end else begin
                        timer_nx = timer - 8'd1;
                    end
                end
                HOLD: begin
                    state_nx = HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state   <= IDLE;
            timer   <= 8'd0;
            BeepCnt <= 3'd0;
            Buzzer  <= 1'b0;
        end else begin
            state   <= state_nx;
            timer   <= timer_nx;
            BeepCnt <= beep_nx;
            Buzzer  <= (state_nx == ON);
        end
    end

endmodule
